// File: rtl/rpsc_pkg.sv
// Shared definitions for the first-fault capture block.
//   rpsc_state_t  : capture state (ARMED, CAPTURED, REPORTED)
//   rpsc_report_t : report word layout {index, stamp}, MSB first
//   RPSC_*        : default channel count and field widths
package rpsc_pkg;

    localparam int RPSC_N_CH  = 8;
    localparam int RPSC_TS_W  = 16;
    localparam int RPSC_CNT_W = 8;
    localparam int RPSC_IDX_W = $clog2(RPSC_N_CH);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CAPTURED = 2'd1,
        REPORTED = 2'd2
    } rpsc_state_t;

    typedef struct packed {
        logic [RPSC_IDX_W-1:0] index;
        logic [RPSC_TS_W-1:0]  stamp;
    } rpsc_report_t;

endpackage

// File: rtl/rpsc_prio_enc.sv
// Lowest-index-first priority encoder (combinational).
//   vec   : request vector, bit i = channel i
//   found : at least one bit of vec is set
//   index : position of the lowest set bit (0 when found = 0)
module rpsc_prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rpsc_first_fault_capture.sv
// First-out fault capture for the latched-alarm (LA) lines.
// Records the first channel to rise, the timer value at that moment and the
// mask of all channels that rose in the same cycle, then offers {index, time}
// as a report word. The capture is held until the report has been taken, the
// operator acknowledges and every LA line is low again.
//   clk, reset       : clock; asynchronous active-low reset
//   LA_Test          : lamp test, masks all rising edges while high
//   fault_la         : latched-alarm lines (same clock domain)
//   ack              : operator acknowledge (level)
//   ff_valid         : a capture is held
//   ff_index/simul   : first channel / all channels rising in the capture cycle
//   ff_time          : time-since-armed at capture, in clk cycles
//   fault_any        : registered OR of fault_la
//   evt_cnt          : saturating count of cycles with any unmasked rising edge
//   rpt_valid/ready  : report handshake. rpt_data is held constant while
//                      rpt_valid is high, and rpt_valid falls only in the cycle
//                      after a clock edge that sees rpt_valid && rpt_ready.
//                      rpt_ready with rpt_valid low has no effect.
//   rpt_data         : {ff_index, ff_time}
//   fsm_state        : current capture state, for observation
module rpsc_first_fault_capture
    import rpsc_pkg::*;
#(
    parameter  int N_CH  = RPSC_N_CH,
    parameter  int TS_W  = RPSC_TS_W,
    parameter  int CNT_W = RPSC_CNT_W,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LA_Test,
    input  logic [N_CH-1:0]    fault_la,
    input  logic               ack,
    output logic               ff_valid,
    output logic [IDX_W-1:0]   ff_index,
    output logic [N_CH-1:0]    ff_simul,
    output logic [TS_W-1:0]    ff_time,
    output logic               fault_any,
    output logic [CNT_W-1:0]   evt_cnt,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [IDX_W+TS_W-1:0] rpt_data,
    output rpsc_state_t        fsm_state
);

    rpsc_state_t       state;
    logic [N_CH-1:0]   prev;
    logic [TS_W-1:0]   timer;
    logic [N_CH-1:0]   rise;
    logic              rise_found;
    logic [IDX_W-1:0]  rise_index;

    // prev tracks fault_la even during lamp test, so a line that rose under
    // lamp test is already "old" when the test ends and is never captured.
    assign rise = fault_la & ~prev & {N_CH{~LA_Test}};

    rpsc_prio_enc #(
        .N  (N_CH),
        .IW (IDX_W)
    ) u_prio (
        .vec   (rise),
        .found (rise_found),
        .index (rise_index)
    );

    assign rpt_data  = {ff_index, ff_time};
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARMED;
            prev      <= '0;
            timer     <= '0;
            ff_valid  <= 1'b0;
            ff_index  <= '0;
            ff_simul  <= '0;
            ff_time   <= '0;
            fault_any <= 1'b0;
            evt_cnt   <= '0;
            rpt_valid <= 1'b0;
        end else begin
            prev      <= fault_la;
            fault_any <= |fault_la;

            if (rise_found && (evt_cnt != '1)) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
            end

            case (state)
                ARMED: begin
                    if (timer != '1) begin
                        timer <= timer + TS_W'(1);
                    end
                    if (rise_found) begin
                        ff_index  <= rise_index;
                        ff_simul  <= rise;
                        ff_time   <= timer;
                        ff_valid  <= 1'b1;
                        rpt_valid <= 1'b1;
                        state     <= CAPTURED;
                    end
                end
                CAPTURED: begin
                    if (rpt_valid && rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= REPORTED;
                    end
                end
                REPORTED: begin
                    // Release only once every LA line has cleared.
                    if (ack && (fault_la == '0)) begin
                        ff_valid <= 1'b0;
                        ff_index <= '0;
                        ff_simul <= '0;
                        ff_time  <= '0;
                        timer    <= '0;
                        state    <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpsc_first_fault_capture.sv
// Bench for rpsc_first_fault_capture: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_rpsc_first_fault_capture;
    import rpsc_pkg::*;

    localparam int N  = 8;
    localparam int TW = 16;
    localparam int CW = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            la_test;
    logic [N-1:0]    fault_la;
    logic            ack;
    logic            rpt_ready;
    logic            ff_valid;
    logic [IW-1:0]   ff_index;
    logic [N-1:0]    ff_simul;
    logic [TW-1:0]   ff_time;
    logic            fault_any;
    logic [CW-1:0]   evt_cnt;
    logic            rpt_valid;
    logic [IW+TW-1:0] rpt_data;
    rpsc_state_t     fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    rpsc_state_t   m_state;
    logic [N-1:0]  m_prev;
    logic [TW-1:0] m_timer;
    logic          m_valid;
    logic [IW-1:0] m_idx;
    logic [N-1:0]  m_simul;
    logic [TW-1:0] m_time;
    logic          m_any;
    int            m_evt;
    logic          m_rvalid;

    rpsc_first_fault_capture dut (
        .clk       (clk),
        .reset     (reset),
        .LA_Test   (la_test),
        .fault_la  (fault_la),
        .ack       (ack),
        .ff_valid  (ff_valid),
        .ff_index  (ff_index),
        .ff_simul  (ff_simul),
        .ff_time   (ff_time),
        .fault_any (fault_any),
        .evt_cnt   (evt_cnt),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_data  (rpt_data),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i[IW-1:0];
        return r;
    endfunction

    task automatic model_reset();
        m_state = ARMED; m_prev = '0; m_timer = '0; m_valid = 1'b0;
        m_idx = '0; m_simul = '0; m_time = '0; m_any = 1'b0;
        m_evt = 0; m_rvalid = 1'b0;
    endtask

    // One clock of the model, from the inputs present at the edge.
    task automatic model_clock();
        logic [N-1:0] e;
        e = la_test ? '0 : (fault_la & ~m_prev);
        if (e != 0 && m_evt < 255) m_evt++;
        m_prev = fault_la;
        m_any  = (fault_la != 0);
        if (m_state == ARMED) begin
            if (e != 0) begin
                m_idx = lowest(e); m_simul = e; m_time = m_timer;
                m_valid = 1'b1; m_rvalid = 1'b1; m_state = CAPTURED;
            end
            if (m_timer != 16'hFFFF) m_timer++;
        end else if (m_state == CAPTURED) begin
            if (rpt_ready) begin
                m_rvalid = 1'b0; m_state = REPORTED;
            end
        end else begin
            if (ack && fault_la == 0) begin
                m_valid = 1'b0; m_idx = '0; m_simul = '0; m_time = '0;
                m_timer = '0; m_state = ARMED;
            end
        end
    endtask

    task automatic check_all();
        rpsc_report_t r;
        r.index = m_idx;
        r.stamp = m_time;
        check("ff_valid",  ff_valid,  m_valid);
        check("ff_index",  ff_index,  m_idx);
        check("ff_simul",  ff_simul,  m_simul);
        check("ff_time",   ff_time,   m_time);
        check("fault_any", fault_any, m_any);
        check("evt_cnt",   evt_cnt,   m_evt[CW-1:0]);
        check("rpt_valid", rpt_valid, m_rvalid);
        check("rpt_data",  rpt_data,  r);
        check("fsm_state", fsm_state, m_state);
    endtask

    // Driver tasks: inputs change at posedge+1, outputs sampled at posedge+1.
    task automatic step();
        @(posedge clk);
        if (reset) model_clock();
        #1 check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        rpsc_report_t r;
        reset = 1'b0; la_test = 1'b0; fault_la = '0; ack = 1'b0; rpt_ready = 1'b0;
        model_reset();
        do_reset();

        // T1: first fault on bit 5 with timer at 10
        repeat (10) step();
        fault_la = 8'h20;
        step();
        r.index = 3'd5; r.stamp = 16'd10;
        check("t1_idx",   ff_index, 3'd5);
        check("t1_simul", ff_simul, 8'h20);
        check("t1_time",  ff_time,  16'd10);
        check("t1_data",  rpt_data, r);
        check("t1_evt",   evt_cnt,  8'd1);

        // T3: consumer stalls, report must hold
        repeat (20) begin
            step();
            check("t3_valid", rpt_valid, 1'b1);
            check("t3_data",  rpt_data,  r);
        end
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        check("t3_taken", rpt_valid, 1'b0);

        // T4: ack ignored while a fault is still high, honoured once clear
        fault_la = 8'h28;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_held", ff_valid, 1'b1);
        check("t4_evt",  evt_cnt,  8'd2);
        fault_la = '0;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_clr_valid", ff_valid, 1'b0);
        check("t4_clr_idx",   ff_index, 3'd0);
        check("t4_clr_simul", ff_simul, 8'h00);
        check("t4_clr_time",  ff_time,  16'd0);

        // T2: simultaneous rise on 6 and 2; timer restarted from 0
        repeat (4) step();
        fault_la = 8'h44;
        step();
        check("t2_idx",   ff_index, 3'd2);
        check("t2_simul", ff_simul, 8'h44);
        check("t2_time",  ff_time,  16'd4);
        check("t2_evt",   evt_cnt,  8'd3);
        fault_la = 8'h45;
        step();
        check("t2_hold_idx",   ff_index, 3'd2);
        check("t2_hold_simul", ff_simul, 8'h44);
        check("t2_evt2",       evt_cnt,  8'd4);
        rpt_ready = 1'b1; step(); rpt_ready = 1'b0;
        fault_la = '0; step();
        ack = 1'b1; step(); ack = 1'b0;

        // T5: rise under lamp test is never captured
        la_test = 1'b1; fault_la = 8'h02;
        step(); step();
        la_test = 1'b0;
        step(); step();
        check("t5_nocap", ff_valid,  1'b0);
        check("t5_evt",   evt_cnt,   8'd4);
        check("t5_any",   fault_any, 1'b1);
        fault_la = '0;
        step();

        // T6: fault held through reset release, then async reset mid-report
        fault_la = 8'h80;
        do_reset();
        step();
        check("t6_valid", ff_valid, 1'b1);
        check("t6_idx",   ff_index, 3'd7);
        check("t6_time",  ff_time,  16'd0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check("t6_async_rv", rpt_valid, 1'b0);
        check("t6_async_fv", ff_valid,  1'b0);
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;
        fault_la = '0;
        step();

        // evt_cnt saturation: 300 rising edges on bit 0
        for (int i = 0; i < 600; i++) begin
            fault_la[0] = ~fault_la[0];
            step();
        end
        check("sat_evt", evt_cnt, 8'hFF);
        fault_la = '0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) fault_la[b] = ~fault_la[b];
            if ($urandom_range(0, 15) == 0) fault_la = '0;
            if ($urandom_range(0, 19) == 0) la_test = ~la_test;
            ack       = ($urandom_range(0, 3) == 0);
            rpt_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
